// File: rtl/data_sampling_mv.sv
// Majority-vote sampler for the UART receive path: votes NUM_SAMPLES samples of RX_IN
// centred on each bit period and reports the voted bit, a valid strobe and a noise flag.
module data_sampling_mv #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  sampled_bit,
    output logic                  samp_valid,
    output logic                  noise_err
);

    localparam int PW1   = PRESCALE_W + 1;
    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int H     = (NUM_SAMPLES - 1) / 2;

    generate
        if (NUM_SAMPLES < 1 || NUM_SAMPLES > 7 || (NUM_SAMPLES % 2) == 0) begin : g_bad_num_samples
            $error("data_sampling_mv: NUM_SAMPLES must be odd and within 1..7");
        end
    endgenerate

    typedef enum logic {IDLE, COLLECT} state_t;

    logic [IDX_W-1:0] samp_idx_q, samp_idx_d;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic             sampled_bit_q, sampled_bit_d;
    logic             samp_valid_q, samp_valid_d;
    logic             noise_err_q, noise_err_d;

    state_t           state;
    logic             degraded;
    logic [PW1-1:0]   center;
    logic [PW1-1:0]   first_pos;
    logic [PW1-1:0]   target_pos;
    logic [CNT_W-1:0] n_eff;
    logic [IDX_W-1:0] last_idx;
    logic [CNT_W-1:0] total;
    logic             hit;
    logic             abort;

    // Too few edges per bit for a full window: fall back to a single centre sample.
    assign degraded   = ({1'b0, Prescale} < PW1'(NUM_SAMPLES + 2));
    assign center     = {1'b0, Prescale} >> 1;
    assign first_pos  = degraded ? center : (center - PW1'(H));
    assign n_eff      = degraded ? CNT_W'(1) : CNT_W'(NUM_SAMPLES);
    assign last_idx   = degraded ? '0 : IDX_W'(NUM_SAMPLES - 1);
    assign target_pos = first_pos + PW1'(samp_idx_q);
    assign hit        = ({1'b0, edge_cnt} == target_pos);
    assign total      = ones_cnt_q + CNT_W'(RX_IN);
    assign state      = (samp_idx_q == '0) ? IDLE : COLLECT;
    assign abort      = !dat_samp_en || (state == COLLECT && edge_cnt == '0);

    always_comb begin
        samp_idx_d    = samp_idx_q;
        ones_cnt_d    = ones_cnt_q;
        sampled_bit_d = sampled_bit_q;
        noise_err_d   = noise_err_q;
        samp_valid_d  = 1'b0;
        if (abort) begin
            samp_idx_d = '0;
            ones_cnt_d = '0;
        end else if (hit) begin
            if (samp_idx_q == last_idx) begin
                samp_idx_d    = '0;
                ones_cnt_d    = '0;
                samp_valid_d  = 1'b1;
                sampled_bit_d = (total > (n_eff >> 1));
                noise_err_d   = !degraded && (total != '0) && (total != n_eff);
            end else begin
                samp_idx_d = samp_idx_q + IDX_W'(1);
                ones_cnt_d = total;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_idx_q    <= '0;
            ones_cnt_q    <= '0;
            sampled_bit_q <= 1'b0;
            samp_valid_q  <= 1'b0;
            noise_err_q   <= 1'b0;
        end else begin
            samp_idx_q    <= samp_idx_d;
            ones_cnt_q    <= ones_cnt_d;
            sampled_bit_q <= sampled_bit_d;
            samp_valid_q  <= samp_valid_d;
            noise_err_q   <= noise_err_d;
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign samp_valid  = samp_valid_q;
    assign noise_err   = noise_err_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Directed bench for data_sampling_mv: a 3-sample and a 5-sample instance share one stimulus.
module tb_data_sampling_mv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rx  = 1'b0;
    logic [5:0] edge_c   = '0;
    logic [5:0] prescale = 6'd8;

    logic bit3, val3, noise3;
    logic bit5, val5, noise5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int v3_cnt = 0, v5_cnt = 0;
    int v3_edge = -1, v5_edge = -1;
    int v5_cyc[$];

    always #5 clk = ~clk;

    data_sampling_mv #(.PRESCALE_W(6), .NUM_SAMPLES(3)) dut3 (
        .CLK(clk), .RST(rst), .dat_samp_en(en), .edge_cnt(edge_c), .RX_IN(rx),
        .Prescale(prescale), .sampled_bit(bit3), .samp_valid(val3), .noise_err(noise3)
    );

    data_sampling_mv #(.PRESCALE_W(6), .NUM_SAMPLES(5)) dut5 (
        .CLK(clk), .RST(rst), .dat_samp_en(en), .edge_cnt(edge_c), .RX_IN(rx),
        .Prescale(prescale), .sampled_bit(bit5), .samp_valid(val5), .noise_err(noise5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One oversampling cycle: drive inputs, let one edge pass, then sample outputs.
    task automatic step(input logic e_en, input int e, input logic e_rx);
        en     = e_en;
        edge_c = e[5:0];
        rx     = e_rx;
        @(posedge clk);
        #1;
        cyc++;
        if (val3) begin v3_cnt++; v3_edge = e; end
        if (val5) begin v5_cnt++; v5_edge = e; v5_cyc.push_back(cyc); end
    endtask

    task automatic send_bit(input int p, input logic [15:0] rxv);
        for (int e = 0; e < p; e++) step(1'b1, e, rxv[e]);
    endtask

    task automatic clear_counts();
        v3_cnt = 0; v5_cnt = 0; v3_edge = -1; v5_edge = -1;
        v5_cyc.delete();
    endtask

    logic [15:0] pat [8];
    logic        pbit [8];
    logic        pnoise [8];

    initial begin
        #1;
        chk("reset_bit3", bit3, 0);
        chk("reset_valid3", val3, 0);
        chk("reset_noise3", noise3, 0);
        chk("reset_bit5", bit5, 0);
        chk("reset_valid5", val5, 0);
        chk("reset_noise5", noise5, 0);
        step(1'b0, 0, 1'b0);
        rst = 1'b0;
        step(1'b0, 0, 1'b0);

        // N=3, Prescale=8: positions 3,4,5
        prescale = 6'd8;
        clear_counts();
        send_bit(8, 16'h0018);
        chk("n3_110_strobes", v3_cnt, 1);
        chk("n3_110_edge", v3_edge, 5);
        chk("n3_110_bit", bit3, 1);
        chk("n3_110_noise", noise3, 1);
        clear_counts();
        send_bit(8, 16'h0000);
        chk("n3_000_strobes", v3_cnt, 1);
        chk("n3_000_bit", bit3, 0);
        chk("n3_000_noise", noise3, 0);

        // N=5, Prescale=16: positions 6..10
        step(1'b0, 0, 1'b0);
        prescale = 6'd16;
        clear_counts();
        send_bit(16, 16'h0140);
        chk("n5_10100_strobes", v5_cnt, 1);
        chk("n5_10100_edge", v5_edge, 10);
        chk("n5_10100_bit", bit5, 0);
        chk("n5_10100_noise", noise5, 1);

        pat[0] = 16'h07C0; pbit[0] = 1'b1; pnoise[0] = 1'b0;
        pat[1] = 16'h0000; pbit[1] = 1'b0; pnoise[1] = 1'b0;
        pat[2] = 16'h01C0; pbit[2] = 1'b1; pnoise[2] = 1'b1;
        pat[3] = 16'h0600; pbit[3] = 1'b0; pnoise[3] = 1'b1;
        pat[4] = 16'h0340; pbit[4] = 1'b1; pnoise[4] = 1'b1;
        pat[5] = 16'h0080; pbit[5] = 1'b0; pnoise[5] = 1'b1;
        pat[6] = 16'hF83F; pbit[6] = 1'b0; pnoise[6] = 1'b0;
        pat[7] = 16'h07C0; pbit[7] = 1'b1; pnoise[7] = 1'b0;
        clear_counts();
        for (int b = 0; b < 8; b++) begin
            send_bit(16, pat[b]);
            chk($sformatf("n5_b2b%0d_bit", b), bit5, pbit[b]);
            chk($sformatf("n5_b2b%0d_noise", b), noise5, pnoise[b]);
        end
        chk("n5_b2b_strobes", v5_cnt, 8);
        chk("n5_b2b_logged", v5_cyc.size(), 8);
        for (int i = 1; i < v5_cyc.size(); i++)
            chk($sformatf("n5_b2b_gap%0d", i), v5_cyc[i] - v5_cyc[i-1], 16);

        // N=5, Prescale=6: degraded, single sample at 3
        step(1'b0, 0, 1'b0);
        prescale = 6'd6;
        clear_counts();
        send_bit(6, 16'h0008);
        chk("deg_one_strobes", v5_cnt, 1);
        chk("deg_one_edge", v5_edge, 3);
        chk("deg_one_bit", bit5, 1);
        chk("deg_one_noise", noise5, 0);
        clear_counts();
        send_bit(6, 16'h0037);
        chk("deg_zero_strobes", v5_cnt, 1);
        chk("deg_zero_bit", bit5, 0);
        chk("deg_zero_noise", noise5, 0);

        // Held edge_cnt=4 for three cycles: sampled once (first value 0)
        step(1'b0, 0, 1'b0);
        prescale = 6'd8;
        clear_counts();
        for (int e = 0; e < 3; e++) step(1'b1, e, 1'b0);
        step(1'b1, 3, 1'b1);
        step(1'b1, 4, 1'b0);
        step(1'b1, 4, 1'b1);
        step(1'b1, 4, 1'b1);
        for (int e = 5; e < 8; e++) step(1'b1, e, 1'b0);
        chk("hold_strobes", v3_cnt, 1);
        chk("hold_edge", v3_edge, 5);
        chk("hold_bit", bit3, 0);
        chk("hold_noise", noise3, 1);

        // Enable dropped mid-window
        clear_counts();
        send_bit(8, 16'h0038);
        chk("pre_abort_bit", bit3, 1);
        chk("pre_abort_noise", noise3, 0);
        clear_counts();
        for (int e = 0; e < 3; e++) step(1'b1, e, 1'b0);
        step(1'b1, 3, 1'b1);
        step(1'b0, 4, 1'b1);
        for (int e = 5; e < 8; e++) step(1'b1, e, 1'b0);
        chk("en_abort_strobes", v3_cnt, 0);
        chk("en_abort_bit_hold", bit3, 1);
        chk("en_abort_noise_hold", noise3, 0);
        clear_counts();
        send_bit(8, 16'h0000);
        chk("after_en_abort_bit", bit3, 0);
        chk("after_en_abort_noise", noise3, 0);

        // Bit boundary crossed (4 -> 0) mid-window
        clear_counts();
        for (int e = 0; e < 3; e++) step(1'b1, e, 1'b0);
        step(1'b1, 3, 1'b1);
        step(1'b1, 4, 1'b1);
        for (int e = 0; e < 5; e++) step(1'b1, e, 1'b0);
        step(1'b1, 5, 1'b1);
        for (int e = 6; e < 8; e++) step(1'b1, e, 1'b0);
        chk("edge_abort_strobes", v3_cnt, 1);
        chk("edge_abort_bit", bit3, 0);
        chk("edge_abort_noise", noise3, 1);

        // Asynchronous reset mid-window
        clear_counts();
        send_bit(8, 16'h0038);
        chk("pre_rst_bit", bit3, 1);
        for (int e = 0; e < 3; e++) step(1'b1, e, 1'b0);
        step(1'b1, 3, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_bit", bit3, 0);
        chk("rst_async_valid", val3, 0);
        chk("rst_async_noise", noise3, 0);
        clear_counts();
        step(1'b1, 4, 1'b1);
        rst = 1'b0;
        for (int e = 5; e < 8; e++) step(1'b1, e, 1'b1);
        chk("rst_release_strobes", v3_cnt, 0);
        chk("rst_release_bit", bit3, 0);
        send_bit(8, 16'h0018);
        chk("post_rst_strobes", v3_cnt, 1);
        chk("post_rst_bit", bit3, 1);
        chk("post_rst_noise", noise3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
